// File: rtl/seq_cmp_pkg.sv
// Shared types and helpers for the sequential magnitude comparator.
// Holds the FSM state encoding, the compare-result encoding and the chunk-count helper.
package seq_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    LT = 2'd0,
    EQ = 2'd1,
    GT = 2'd2
  } res_t;

  // Returns WIDTH/CHUNK for a legal configuration, 0 when the split is illegal.
  function automatic int calc_nchunk(input int width, input int chunk);
    if (chunk < 1 || chunk > width || (width % chunk) != 0) return 0;
    return width / chunk;
  endfunction

endpackage

// File: rtl/seq_mag_comparator_if.sv
// Request/response bundle of the sequential magnitude comparator.
// The master drives the operands and start; the slave returns status and result flags.
interface seq_mag_comparator_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             is_signed;
  logic             busy;
  logic             done;
  logic             alb;
  logic             aeb;
  logic             agb;

  modport master (
    output start, a, b, is_signed,
    input  busy, done, alb, aeb, agb
  );

  modport slave (
    input  start, a, b, is_signed,
    output busy, done, alb, aeb, agb
  );
endinterface

// File: rtl/chunk_comparator.sv
// Combinational unsigned comparator for one CHUNK-bit slice.
// Exactly one of lt/eq/gt is high for any pair of inputs.
module chunk_comparator #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  output logic             lt,
  output logic             eq,
  output logic             gt
);
  assign lt = (x < y);
  assign eq = (x == y);
  assign gt = (x > y);
endmodule

// File: rtl/seq_mag_comparator.sv
// Multi-cycle WIDTH-bit magnitude comparator, CHUNK bits per cycle, MSB chunk first,
// stopping at the first differing chunk. Signed mode flips the top sign bit of both operands.
module seq_mag_comparator
  import seq_cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic                clk,
  input logic                rst,
  seq_mag_comparator_if.slave bus
);
  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  if (NCHUNK == 0) begin : g_bad_cfg
    $error("seq_mag_comparator: WIDTH must be a positive multiple of CHUNK");
  end

  state_t                        state_q, state_d;
  logic [IDXW-1:0]               idx_q, idx_d;
  logic [NCHUNK-1:0][CHUNK-1:0]  a_q, b_q;
  logic                          signed_q;
  logic                          load;
  logic                          flag_upd;
  res_t                          res_d;
  logic                          alb_q, aeb_q, agb_q;

  logic [CHUNK-1:0] sign_mask;
  logic [CHUNK-1:0] x_chunk, y_chunk;
  logic             c_lt, c_eq, c_gt;

  // Inverting the top sign bit on both sides turns the unsigned chunk compare into
  // a two's-complement compare; lower chunks are always unsigned.
  always_comb begin
    sign_mask            = '0;
    sign_mask[CHUNK-1]   = signed_q && (idx_q == LAST_IDX);
    x_chunk              = a_q[idx_q] ^ sign_mask;
    y_chunk              = b_q[idx_q] ^ sign_mask;
  end

  chunk_comparator #(.CHUNK(CHUNK)) u_chunk_cmp (
    .x  (x_chunk),
    .y  (y_chunk),
    .lt (c_lt),
    .eq (c_eq),
    .gt (c_gt)
  );

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    load     = 1'b0;
    flag_upd = 1'b0;
    res_d    = EQ;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          load    = 1'b1;
          idx_d   = LAST_IDX;
          state_d = CMP;
        end else begin
          state_d = IDLE;
        end
      end
      CMP: begin
        if (c_gt) begin
          flag_upd = 1'b1;
          res_d    = GT;
          state_d  = DONE;
        end else if (c_lt) begin
          flag_upd = 1'b1;
          res_d    = LT;
          state_d  = DONE;
        end else if (c_eq) begin
          if (idx_q == '0) begin
            flag_upd = 1'b1;
            res_d    = EQ;
            state_d  = DONE;
          end else begin
            idx_d = idx_q - IDXW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= LAST_IDX;
      alb_q   <= 1'b0;
      aeb_q   <= 1'b0;
      agb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (flag_upd) begin
        alb_q <= (res_d == LT);
        aeb_q <= (res_d == EQ);
        agb_q <= (res_d == GT);
      end
    end
  end

  // NOTE: operand registers carry no reset; they are always loaded before being read.
  always_ff @(posedge clk) begin
    if (load) begin
      a_q      <= bus.a;
      b_q      <= bus.b;
      signed_q <= bus.is_signed;
    end
  end

  assign bus.busy = (state_q == CMP);
  assign bus.done = (state_q == DONE);
  assign bus.alb  = alb_q;
  assign bus.aeb  = aeb_q;
  assign bus.agb  = agb_q;

endmodule

// File: doc/seq_mag_comparator.md
Name: seq_mag_comparator

Overview:
- Multi-cycle magnitude comparator for WIDTH-bit operands, processed CHUNK bits per cycle, MSB chunk first, with early termination on the first differing chunk.
- Parametrised successor of the team's 2-bit combinational comparator: adds selectable signed/unsigned mode, a start/busy/done handshake and registered one-hot result flags (alb/aeb/agb).
- Used wherever wide compares must not sit on a single-cycle critical path.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits compared per cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK, WIDTH/CHUNK, derived local constant, not overridable.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a compare; sampled only when not busy.
- a  in  WIDTH  operand A; captured on accepted start.
- b  in  WIDTH  operand B; captured on accepted start.
- is_signed  in  1  1 = two's-complement compare, 0 = unsigned; captured on accepted start.
- busy  out  1  high while a compare is in progress.
- done  out  1  one-cycle pulse when the result flags update.
- alb  out  1  A < B.
- aeb  out  1  A == B.
- agb  out  1  A > B.

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE; busy=0, done=0, alb=aeb=agb=0; chunk index=NCHUNK-1. Reset overrides start and aborts any compare in progress; no done pulse is produced.
- States: IDLE, CMP, DONE.
- IDLE: if start=1, capture a, b and is_signed, set index=NCHUNK-1, go to CMP. Otherwise remain in IDLE. Flags hold their last value.
- CMP: busy=1. Each cycle, compare chunk[index] of the captured A against chunk[index] of the captured B, unsigned.
  - Signed mode: the MSB of chunk NCHUNK-1 is inverted on both operands before comparing. This makes the unsigned chunk compare equal to a two's-complement compare.
  - Chunk A > chunk B: next edge sets agb=1, clears alb and aeb, goes to DONE.
  - Chunk A < chunk B: next edge sets alb=1, clears agb and aeb, goes to DONE.
  - Chunks equal and index=0: next edge sets aeb=1, clears alb and agb, goes to DONE.
  - Chunks equal and index>0: index decrements; stay in CMP.
- DONE: done=1 and busy=0 for exactly one cycle.
  - If start=1 in this cycle, it is accepted (capture, go to CMP). Otherwise go to IDLE.
- Flags are registered, exactly one-hot after the first completed compare, and held until the next completion. Before the first completion all three are 0.
- Latency: start is sampled at edge 0. The result lands and done is high in the cycle after edge k, where k = number of chunks examined (1..NCHUNK).
  - Top chunk differs: k=1.
  - Full equality: k=NCHUNK.
- start while busy=1 (CMP) is ignored and not queued.
- Changes on a, b or is_signed after capture have no effect on the compare in progress.
- CHUNK=WIDTH is legal: every compare takes k=1.

Decomposition:
- Shared package seq_cmp_pkg:
  - state enum (IDLE, CMP, DONE);
  - result encoding constants (LT, EQ, GT);
  - helper function computing NCHUNK and checking the WIDTH%CHUNK==0 legality.
- Sub-module chunk_comparator: purely combinational, parameter CHUNK; inputs x, y; outputs lt, eq, gt (the generalised 2-bit comparator).
- The top level instantiates one chunk_comparator, fed by the index-selected slices with the sign-bit inversion applied.

Test Plan (WIDTH=16, CHUNK=4):
- a=0x1234, b=0x1234, unsigned, start pulse -> busy for 4 cycles, done after edge 4, aeb=1, alb=agb=0.
- a=0x8000, b=0x0001, unsigned -> done after edge 1, agb=1. Same operands with is_signed=1 -> done after edge 1, alb=1.
- a=0x1235, b=0x1234, unsigned -> done after edge 4, agb=1. Then a=0xFFFF, b=0xFFFE, signed -> done after edge 4, agb=1 (-1 > -2).
- a=0x0F00, b=0x0E00 accepted. Then start with a=0x0000, b=0xFFFF while busy -> second request ignored; result agb=1 after edge 2; busy=0 afterwards.
- Back-to-back: start held high through the DONE cycle with new operands a=0x0001, b=0x0002 -> second compare accepted without an IDLE cycle; alb=1 four edges later.
- rst=1 asserted mid-CMP (after edge 2 of a 4-chunk compare) -> next cycle busy=0, done=0, all flags 0; no done pulse follows. Assertion check on every cycle: flags are never more than one-hot.
